// File: rtl/fnd_scan_counter_pkg.sv
// Shared constants for the FND scan counter: active-low 7-segment fonts and BCD limits.
package fnd_pkg;

    localparam logic [7:0] FND_BLANK = 8'hFF;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    // Index 10 is the blank pattern; segment order {dp,g,f,e,d,c,b,a}, active-low.
    localparam logic [7:0] FND_FONT [0:10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90,
        FND_BLANK
    };

    function automatic logic [7:0] bcd_to_font(input logic [3:0] d);
        if (d > BCD_MAX) begin
            return FND_FONT[10];
        end
        return FND_FONT[d];
    endfunction

endpackage

// File: rtl/fnd_scan_counter_if.sv
// Control and display bundle between the board-side logic and the FND scan counter.
interface fnd_scan_counter_if #(
    parameter int DIGITS = 4
);
    logic                  i_run;
    logic                  i_down;
    logic                  i_clear;
    logic                  i_blank_lz;
    logic [DIGITS-1:0]     o_digit;
    logic [7:0]            o_font;
    logic [4*DIGITS-1:0]   o_value;
    logic                  o_tick;

    modport master (
        output i_run, i_down, i_clear, i_blank_lz,
        input  o_digit, o_font, o_value, o_tick
    );

    modport slave (
        input  i_run, i_down, i_clear, i_blank_lz,
        output o_digit, o_font, o_value, o_tick
    );

endinterface

// File: rtl/fnd_scan_counter_bcd_digit.sv
// One cascadable BCD digit: steps up/down when enabled, emits carry (up) or borrow (down).
module bcd_digit
    import fnd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       down_i,
    input  logic       clr_i,
    output logic [3:0] q_o,
    output logic       co_o
);

    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = 4'd0;
        end else if (en_i) begin
            if (down_i) begin
                q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
            end else begin
                q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o  = q_q;
    assign co_o = en_i & (down_i ? (q_q == 4'd0) : (q_q == BCD_MAX));

endmodule

// File: rtl/fnd_scan_counter.sv
// N-digit cascaded BCD up/down counter with time-multiplexed common-anode 7-segment drive.
module fnd_scan_counter
    import fnd_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1_000,
    parameter int COUNT_HZ = 10,
    parameter int DIGITS   = 4,
    parameter int SATURATE = 0
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    fnd_scan_counter_if.slave   bus
);

    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int COUNT_DIV = CLK_HZ / COUNT_HZ;
    localparam int SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("SCAN_DIV = CLK_HZ/SCAN_HZ must be at least 2");
    end
    if (COUNT_DIV < 2) begin : g_bad_count_div
        $error("COUNT_DIV = CLK_HZ/COUNT_HZ must be at least 2");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("DIGITS must be in 1..8");
    end

    logic [SW-1:0]          scan_cnt_q, scan_cnt_d;
    logic [CW-1:0]          count_cnt_q, count_cnt_d;
    logic [IW-1:0]          scan_idx_q, scan_idx_d;
    logic [DIGITS-1:0]      digit_q, digit_d;
    logic [7:0]             font_q, font_d;
    logic                   scan_tick, count_tick;
    logic [4*DIGITS-1:0]    value;
    logic [DIGITS:0]        en;
    logic                   carry_unused;
    logic                   at_max, at_min, at_limit, step;
    logic [DIGITS-1:0]      blank;
    logic                   zero_run;
    logic [3:0]             cur_bcd;
    logic                   cur_blank;

    // Free-running prescalers; each tick is the single cycle at DIV-1.
    assign scan_tick   = (scan_cnt_q == SW'(SCAN_DIV - 1));
    assign count_tick  = (count_cnt_q == CW'(COUNT_DIV - 1));
    assign scan_cnt_d  = scan_tick ? '0 : scan_cnt_q + SW'(1);
    assign count_cnt_d = count_tick ? '0 : count_cnt_q + CW'(1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            scan_cnt_q  <= '0;
            count_cnt_q <= '0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            count_cnt_q <= count_cnt_d;
        end
    end

    // Limit detect and leading-zero scan, walking from the most-significant digit down.
    always_comb begin
        at_max   = 1'b1;
        at_min   = 1'b1;
        zero_run = 1'b1;
        blank    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            at_max   = at_max & (value[4*k +: 4] == BCD_MAX);
            at_min   = at_min & (value[4*k +: 4] == 4'd0);
            zero_run = zero_run & (value[4*k +: 4] == 4'd0);
            blank[k] = bus.i_blank_lz & zero_run & (k > 0);
        end
    end

    assign at_limit = (SATURATE != 0) && (bus.i_down ? at_min : at_max);
    assign step     = count_tick & bus.i_run & ~at_limit;
    assign en[0]    = step;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk_i  (i_clk),
            .rst_ni (i_reset_n),
            .en_i   (en[k]),
            .down_i (bus.i_down),
            .clr_i  (bus.i_clear),
            .q_o    (value[4*k +: 4]),
            .co_o   (en[k+1])
        );
    end

    // Wrap past the top digit is handled by the digits themselves.
    assign carry_unused = en[DIGITS];

    always_comb begin
        scan_idx_d = scan_idx_q;
        if (scan_tick) begin
            scan_idx_d = (scan_idx_q == IW'(DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
        end
    end

    always_comb begin
        digit_d   = '1;
        cur_bcd   = 4'd0;
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (scan_idx_q == IW'(k)) begin
                digit_d[k] = 1'b0;
                cur_bcd    = value[4*k +: 4];
                cur_blank  = blank[k];
            end
        end
        font_d = cur_blank ? FND_BLANK : bcd_to_font(cur_bcd);
    end

    // Digit enable and font are registered together so the pins never disagree.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            scan_idx_q <= '0;
            digit_q    <= ~DIGITS'(1);
            font_q     <= FND_FONT[0];
        end else begin
            scan_idx_q <= scan_idx_d;
            digit_q    <= digit_d;
            font_q     <= font_d;
        end
    end

    assign bus.o_value = value;
    assign bus.o_tick  = count_tick;
    assign bus.o_digit = digit_q;
    assign bus.o_font  = font_q;

endmodule

// File: tb/tb_fnd_scan_counter.sv
// Directed bench: a 4-digit wrapping counter and a 2-digit saturating counter share stimulus.
module tb_fnd_scan_counter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    fnd_scan_counter_if #(.DIGITS(4)) bm ();
    fnd_scan_counter_if #(.DIGITS(2)) bs ();

    fnd_scan_counter #(
        .CLK_HZ(1000), .SCAN_HZ(250), .COUNT_HZ(100), .DIGITS(4), .SATURATE(0)
    ) u_wrap (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bm)
    );

    fnd_scan_counter #(
        .CLK_HZ(1000), .SCAN_HZ(250), .COUNT_HZ(100), .DIGITS(2), .SATURATE(1)
    ) u_sat (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bs)
    );

    int total = 0;
    int bad   = 0;
    int n     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic run, input logic down, input logic clr, input logic blz);
        bm.i_run = run;  bm.i_down = down;  bm.i_clear = clr;  bm.i_blank_lz = blz;
        bs.i_run = run;  bs.i_down = down;  bs.i_clear = clr;  bs.i_blank_lz = blz;
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Displayed digit after n edges: index advanced at edge 4,8,..., shown one edge later.
    function automatic logic [3:0] exp_digit(input int cnt);
        logic [3:0] one;
        one = 4'h1;
        if (cnt == 0) return 4'hE;
        return ~(one << (((cnt - 1) / 4) % 4));
    endfunction

    function automatic int disp_idx(input int cnt);
        return ((cnt - 1) / 4) % 4;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_value", bm.o_value, 32'h0);
        chk("rst_tick", bm.o_tick, 32'h0);
        chk("rst_digit", bm.o_digit, 32'hE);
        chk("rst_font", bm.o_font, 32'hC0);
        chk("rst_sat_digit", bs.o_digit, 32'h2);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;

        // Reset and scan with counting disabled
        do_reset();
        for (int i = 0; i < 20; i++) begin
            chk("scan_digit", bm.o_digit, exp_digit(n));
            chk("scan_font", bm.o_font, 32'hC0);
            chk("scan_tick", bm.o_tick, (n % 10 == 9) ? 32'h1 : 32'h0);
            cyc(1);
        end
        chk("idle_value", bm.o_value, 32'h0);

        // Count up with carries
        do_reset();
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(9);
        chk("first_tick", bm.o_tick, 32'h1);
        chk("first_tick_value", bm.o_value, 32'h0);
        cyc(1);
        chk("first_step", bm.o_value, 32'h1);
        chk("tick_gone", bm.o_tick, 32'h0);
        cyc(90);
        chk("up_10", bm.o_value, 32'h0010);
        chk("sat_up_10", bs.o_value, 32'h10);
        cyc(890);
        chk("up_99", bm.o_value, 32'h0099);
        chk("sat_reach_max", bs.o_value, 32'h99);
        cyc(10);
        chk("up_100", bm.o_value, 32'h0100);
        chk("sat_hold_max", bs.o_value, 32'h99);
        cyc(8990);
        chk("preload_0999", bm.o_value, 32'h0999);
        cyc(10);
        chk("carry_1000", bm.o_value, 32'h1000);
        chk("sat_still_max", bs.o_value, 32'h99);

        // Wrap down from 0 and up from MAX; saturate holds at 0
        set_in(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1);
        chk("clear", bm.o_value, 32'h0);
        chk("sat_clear", bs.o_value, 32'h0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(9);
        chk("wrap_down", bm.o_value, 32'h9999);
        chk("sat_hold_min", bs.o_value, 32'h00);
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(10);
        chk("wrap_up", bm.o_value, 32'h0000);
        chk("sat_leave_min", bs.o_value, 32'h01);

        // Clear colliding with a tick, then stopped counting
        cyc(420);
        chk("at_42", bm.o_value, 32'h0042);
        cyc(9);
        set_in(1'b1, 1'b0, 1'b1, 1'b0);
        chk("clr_tick_pulse", bm.o_tick, 32'h1);
        cyc(1);
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        chk("clr_over_tick", bm.o_value, 32'h0);
        chk("sat_clr_over_tick", bs.o_value, 32'h0);
        cyc(30);
        chk("after_clear_3", bm.o_value, 32'h3);
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(51);
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(5);
        chk("run_off_hold", bm.o_value, 32'h3);

        // Leading-zero blanking
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(40);
        chk("at_7", bm.o_value, 32'h7);
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            chk("blank7_digit", bm.o_digit, exp_digit(n));
            chk("blank7_font", bm.o_font, (disp_idx(n) == 0) ? 32'hF8 : 32'hFF);
        end
        set_in(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1);
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1);
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            chk("blank0_font", bm.o_font, (disp_idx(n) == 0) ? 32'hC0 : 32'hFF);
        end

        // Asynchronous reset between edges at 0x0123
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1239);
        chk("pre_areset_value", bm.o_value, 32'h0123);
        chk("pre_areset_tick", bm.o_tick, 32'h1);
        chk("pre_areset_digit", bm.o_digit, 32'hD);
        chk("pre_areset_font", bm.o_font, 32'hA4);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_value", bm.o_value, 32'h0);
        chk("areset_tick", bm.o_tick, 32'h0);
        chk("areset_digit", bm.o_digit, 32'hE);
        chk("areset_font", bm.o_font, 32'hC0);
        chk("areset_sat_value", bs.o_value, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        cyc(8);
        chk("rel_no_early_tick", bm.o_tick, 32'h0);
        chk("rel_value", bm.o_value, 32'h0);
        cyc(1);
        chk("rel_first_tick", bm.o_tick, 32'h1);
        cyc(1);
        chk("rel_first_step", bm.o_value, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
